datapath_seq: RTL and testbench

Operand sequencer that sits directly upstream of the `Datapath` stage (register file plus ALU). It accepts a complete two-operand request (A, B, op, register addresses) over a valid/ready handshake. It then drives `Din`/`WE`/`W1` to write A and B into the register file on consecutive cycles, and selects both registers and the ALU opcode. Finally it captures `ALU_out` into a held result presented over a second valid/ready handshake.

---
 rtl/datapath_pkg.sv | 29 ++
 rtl/datapath_seq.sv | 172 +++++++++++++++++
 tb/tb_datapath_seq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the operand sequencer (datapath_seq) and the
// Datapath stage it drives: default operand width, index/opcode widths,
// the sequencer state encoding and the ALU mode-select (MS) opcodes.
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int SIZE_DATA = 16;  // operand/result width, matches Datapath
    localparam int OP_W      = 3;   // ALU mode-select width
    localparam int IDX_W     = 3;   // register-file index width (8 registers)

    // Sequencer state encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_A = 3'd1,
        ST_WR_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // ALU mode-select opcodes shared with the Datapath ALU.
    localparam logic [OP_W-1:0] MS_ADD = 3'b000;
    localparam logic [OP_W-1:0] MS_SUB = 3'b001;
    localparam logic [OP_W-1:0] MS_AND = 3'b010;
    localparam logic [OP_W-1:0] MS_OR  = 3'b011;
    localparam logic [OP_W-1:0] MS_XOR = 3'b100;

endpackage : datapath_pkg

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
// Operand sequencer sitting directly upstream of the Datapath stage
// (register file + ALU). It accepts one two-operand request over a
// valid/ready handshake, writes A then B into the register file on
// consecutive cycles, selects both registers and the ALU opcode for one
// cycle, captures ALU_out and presents it over a second valid/ready
// handshake.
//
// Ports
//   CLK, RST_N        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only in IDLE)
//   in_a, in_b        operands A, B            [size_data]
//   in_op             ALU opcode -> MS         [3]
//   in_ra, in_rb      register indices for A/B [3]
//   Din, WE, W1       register-file write port (active in WR_A / WR_B)
//   num_R1, num_R2    register-file read indices (ALU operands 1, 2)
//   MS                ALU mode select
//   ALU_out           combinational ALU result from Datapath
//   result            captured ALU result      [size_data]
//   out_valid/out_ready result handshake (result held while stalled)
// -----------------------------------------------------------------------------
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int size_data = SIZE_DATA
) (
    input  logic                 CLK,
    input  logic                 RST_N,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [size_data-1:0] in_a,
    input  logic [size_data-1:0] in_b,
    input  logic [OP_W-1:0]      in_op,
    input  logic [IDX_W-1:0]     in_ra,
    input  logic [IDX_W-1:0]     in_rb,

    output logic [size_data-1:0] Din,
    output logic                 WE,
    output logic [IDX_W-1:0]     W1,
    output logic [IDX_W-1:0]     num_R1,
    output logic [IDX_W-1:0]     num_R2,
    output logic [OP_W-1:0]      MS,
    input  logic [size_data-1:0] ALU_out,

    output logic [size_data-1:0] result,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t state;
    state_t state_next;

    // Latched request.
    logic [size_data-1:0] a_q;
    logic [size_data-1:0] b_q;
    logic [OP_W-1:0]      op_q;
    logic [IDX_W-1:0]     ra_q;
    logic [IDX_W-1:0]     rb_q;

    logic accept;
    assign accept = (state == ST_IDLE) && in_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_next = ST_WR_A;
            ST_WR_A:                state_next = ST_WR_B;
            ST_WR_B:                state_next = ST_EXEC;
            ST_EXEC:                state_next = ST_RESP;
            ST_RESP: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write port, decoded from state and the latched request.
    // Zero outside the two write cycles so nothing stale reaches Datapath.
    // ------------------------------------------------------------------
    always_comb begin
        WE  = 1'b0;
        W1  = '0;
        Din = '0;
        unique case (state)
            ST_WR_A: begin
                WE  = 1'b1;
                W1  = ra_q;
                Din = a_q;
            end
            ST_WR_B: begin
                WE  = 1'b1;
                W1  = rb_q;
                Din = b_q;
            end
            default: ;
        endcase
    end

    // Gated by RST_N so the request port reads not-ready throughout reset.
    assign in_ready  = (state == ST_IDLE) && RST_N;
    assign out_valid = (state == ST_RESP);

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    // NOTE: these are a handful of flops rather than a memory, so they get
    // a reset like everything else; that keeps Din/MS free of X after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= in_op;
            ra_q <= in_ra;
            rb_q <= in_rb;
        end
    end

    // ------------------------------------------------------------------
    // Read-select / opcode registers. Loaded on the WR_B -> EXEC edge so
    // they are valid for the whole EXEC cycle, then simply held: Datapath
    // ignores them outside EXEC, and holding avoids needless toggling.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_R1 <= '0;
            num_R2 <= '0;
            MS     <= '0;
        end else if (state == ST_WR_B) begin
            num_R1 <= ra_q;
            num_R2 <= rb_q;
            MS     <= op_q;
        end
    end

    // ------------------------------------------------------------------
    // Result register: captures ALU_out at the end of EXEC and holds it
    // through any amount of output backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result <= '0;
        end else if (state == ST_EXEC) begin
            result <= ALU_out;
        end
    end

endmodule : datapath_seq

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
// Self-checking bench for datapath_seq. A behavioural register file + ALU
// stands in for Datapath; expected results come from hand-written vectors
// and from an arithmetic reference model of the request semantics
// (including the ra == rb aliasing rule).
// -----------------------------------------------------------------------------
module tb_datapath_seq;
    import datapath_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic [2:0]   in_ra = '0;
    logic [2:0]   in_rb = '0;
    logic [W-1:0] Din;
    logic         WE;
    logic [2:0]   W1;
    logic [2:0]   num_R1;
    logic [2:0]   num_R2;
    logic [2:0]   MS;
    logic [W-1:0] ALU_out;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready = 1'b1;

    always #5 clk = ~clk;

    datapath_seq #(.size_data(W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .Din       (Din),
        .WE        (WE),
        .W1        (W1),
        .num_R1    (num_R1),
        .num_R2    (num_R2),
        .MS        (MS),
        .ALU_out   (ALU_out),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Datapath stand-in: un-reset register file, combinational reads.
    logic [W-1:0] rf [8];
    always @(posedge clk) if (WE) rf[W1] <= Din;

    function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            MS_ADD:  return x + y;
            MS_SUB:  return x - y;
            MS_AND:  return x & y;
            MS_OR:   return x | y;
            MS_XOR:  return x ^ y;
            default: return x;
        endcase
    endfunction

    always_comb ALU_out = alu(MS, rf[num_R1], rf[num_R2]);

    // Reference model: what one request should produce, from the request alone.
    function automatic logic [W-1:0] model(input int unsigned a, input int unsigned b,
                                           input int unsigned op, input int unsigned ra,
                                           input int unsigned rb);
        int unsigned x;
        int unsigned r;
        x = (ra == rb) ? b : a;   // B overwrites A when both target one register
        case (op)
            0:       r = (x + b) % 65536;
            1:       r = (x + 65536 - b) % 65536;
            2:       r = x & b;
            3:       r = x | b;
            4:       r = x ^ b;
            default: r = x;
        endcase
        return r[W-1:0];
    endfunction

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int last_accept = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [2:0]   ra;
        logic [2:0]   rb;
        logic [W-1:0] exp;
        int           stall;
    } vec_t;

    // One full transaction. Must be entered at a stable time (just after a
    // negedge). If keep is set, the next request is presented immediately
    // after this one is accepted so in_valid never drops.
    task automatic run_txn(input vec_t v, input bit keep, input vec_t nxt);
        bit hs;
        int waited;
        in_a = v.a; in_b = v.b; in_op = v.op; in_ra = v.ra; in_rb = v.rb;
        in_valid  = 1'b1;
        out_ready = (v.stall == 0);
        hs = 1'b0;
        waited = 0;
        while (!hs && waited < 60) begin
            hs = in_ready;
            @(posedge clk);
            if (!hs) begin
                @(negedge clk);
                waited++;
            end
        end
        if (!hs) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        #1;
        last_accept = cycle;
        if (keep) begin
            in_a = nxt.a; in_b = nxt.b; in_op = nxt.op; in_ra = nxt.ra; in_rb = nxt.rb;
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);   // WR_A
        check("wr_a_we",  32'(WE), 32'd1);
        check("wr_a_w1",  32'(W1), 32'(v.ra));
        check("wr_a_din", 32'(Din), 32'(v.a));
        check("wr_a_inr", 32'(in_ready), 32'd0);
        @(negedge clk);   // WR_B
        check("wr_b_we",  32'(WE), 32'd1);
        check("wr_b_w1",  32'(W1), 32'(v.rb));
        check("wr_b_din", 32'(Din), 32'(v.b));
        @(negedge clk);   // EXEC
        check("exec_we",  32'(WE), 32'd0);
        check("exec_din", 32'(Din), 32'd0);
        check("exec_r1",  32'(num_R1), 32'(v.ra));
        check("exec_r2",  32'(num_R2), 32'(v.rb));
        check("exec_ms",  32'(MS), 32'(v.op));
        check("exec_ov",  32'(out_valid), 32'd0);
        @(negedge clk);   // RESP, 3 edges after accept
        check("resp_ov",  32'(out_valid), 32'd1);
        check("resp_res", 32'(result), 32'(v.exp));
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            check("stall_ov",  32'(out_valid), 32'd1);
            check("stall_res", 32'(result), 32'(v.exp));
            check("stall_inr", 32'(in_ready), 32'd0);
            check("stall_we",  32'(WE), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);   // back in IDLE
        check("idle_ov",  32'(out_valid), 32'd0);
        check("idle_inr", 32'(in_ready), 32'd1);
        check("idle_we",  32'(WE), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   prev;
        vecs[0] = '{a: 16'd7,     b: 16'd5,     op: MS_ADD, ra: 3'd1, rb: 3'd2, exp: 16'd12,    stall: 0};
        vecs[1] = '{a: 16'h0003,  b: 16'h0005,  op: MS_SUB, ra: 3'd3, rb: 3'd5, exp: 16'hFFFE,  stall: 10};
        vecs[2] = '{a: 16'd9,     b: 16'd3,     op: MS_ADD, ra: 3'd4, rb: 3'd4, exp: 16'd6,     stall: 0};
        vecs[3] = '{a: 16'hFFFF,  b: 16'h0001,  op: MS_ADD, ra: 3'd0, rb: 3'd7, exp: 16'h0000,  stall: 0};
        vecs[4] = '{a: 16'hF0F0,  b: 16'h3C3C,  op: MS_AND, ra: 3'd6, rb: 3'd5, exp: 16'h3030,  stall: 2};
        vecs[5] = '{a: 16'hAAAA,  b: 16'hFFFF,  op: MS_XOR, ra: 3'd2, rb: 3'd3, exp: 16'h5555,  stall: 0};
        vecs[6] = '{a: 16'h1200,  b: 16'h0034,  op: MS_OR,  ra: 3'd1, rb: 3'd0, exp: 16'h1234,  stall: 3};
        vecs[7] = '{a: 16'h0000,  b: 16'h0001,  op: MS_SUB, ra: 3'd7, rb: 3'd0, exp: 16'hFFFF,  stall: 0};

        // Reset state.
        #12;
        check("rst_inr", 32'(in_ready), 32'd0);
        check("rst_we",  32'(WE), 32'd0);
        check("rst_din", 32'(Din), 32'd0);
        check("rst_w1",  32'(W1), 32'd0);
        check("rst_r1",  32'(num_R1), 32'd0);
        check("rst_r2",  32'(num_R2), 32'd0);
        check("rst_ms",  32'(MS), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_ov",  32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_inr", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed table, valid held continuously from one request to the next.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], (i < 7), (i < 7) ? vecs[i+1] : vecs[i]);
            if (i > 0) check($sformatf("accept_gap_%0d", i), 32'(last_accept - prev), 32'(5 + vecs[i-1].stall));
            prev = last_accept;
        end

        // Randomised requests against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.a     = W'($urandom);
            v.b     = W'($urandom);
            v.op    = 3'($urandom_range(0, 4));
            v.ra    = 3'($urandom_range(0, 7));
            v.rb    = ($urandom_range(0, 3) == 0) ? v.ra : 3'($urandom_range(0, 7));
            v.stall = $urandom_range(0, 3);
            v.exp   = model(v.a, v.b, v.op, v.ra, v.rb);
            run_txn(v, 1'b0, v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset asserted in WR_B while WE is high.
        in_a = 16'h1111; in_b = 16'h2222; in_op = MS_ADD; in_ra = 3'd2; in_rb = 3'd3;
        check("pre_rst_inr", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("wrb_we_before_rst", 32'(WE), 32'd1);
        rst_n = 1'b0;
        #1;
        check("wrb_rst_we",  32'(WE), 32'd0);
        check("wrb_rst_ov",  32'(out_valid), 32'd0);
        check("wrb_rst_inr", 32'(in_ready), 32'd0);
        check("wrb_rst_w1",  32'(W1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("wrb_rel_inr", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("wrb_idle_we", 32'(WE), 32'd0);
        check("wrb_idle_ov", 32'(out_valid), 32'd0);

        // Reset asserted in RESP under backpressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("resp_before_rst_ov", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("resp_rst_ov",  32'(out_valid), 32'd0);
        check("resp_rst_res", 32'(result), 32'd0);
        check("resp_rst_ms",  32'(MS), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Normal operation resumes after reset.
        run_txn(vecs[0], 1'b0, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_datapath_seq
